// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared mode encodings and saturating adder for the PE family
//
// Purpose : mode encodings and a width-generic saturating add used by
//           pe_mac_dbuf when built with PE_SAT_EN.
// Contents: PE_MODE_WS / PE_MODE_OS, SAT_W, sat_res_t, sat_add().

package pe_pkg;

  localparam logic PE_MODE_WS = 1'b0;
  localparam logic PE_MODE_OS = 1'b1;

  // Operands are widened to SAT_W before the add so the true sum never
  // wraps; ACC_W must therefore stay at least two bits below SAT_W.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic [SAT_W-1:0] sum;
    logic             clamp;
  } sat_res_t;

  // x and y must already be sign- or zero-extended to SAT_W from acc_w bits.
  // The result is clamped to the acc_w range for the given signedness.
  function automatic sat_res_t sat_add(input logic [SAT_W-1:0] x,
                                       input logic [SAT_W-1:0] y,
                                       input int               acc_w,
                                       input logic             is_signed);
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                res;
    one = SAT_W'(1);
    s   = x + y;
    if (is_signed) begin
      hi = (one <<< (acc_w - 1)) - one;
      lo = -(one <<< (acc_w - 1));
    end else begin
      hi = (one <<< acc_w) - one;
      lo = '0;
    end
    res.sum   = s;
    res.clamp = 1'b0;
    if (s > hi) begin
      res.sum   = hi;
      res.clamp = 1'b1;
    end else if (s < lo) begin
      res.sum   = lo;
      res.clamp = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_mul.sv
// rtl/pe_mul.sv - combinational DATA_W x W_W multiplier for the PE
//
// Purpose: full-width product of the activation and the selected weight,
//          signed or unsigned per SIGNED; written to map onto a DSP block.
// Ports  : i_a [DATA_W]      activation operand
//          i_b [W_W]         weight / streaming operand
//          o_p [DATA_W+W_W]  full-precision product

module pe_mul #(
  parameter int DATA_W = 8,
  parameter int W_W    = 8,
  parameter int SIGNED = 1
) (
  input  logic [DATA_W-1:0]     i_a,
  input  logic [W_W-1:0]        i_b,
  output logic [DATA_W+W_W-1:0] o_p
);

  localparam int PROD_W = DATA_W + W_W;

  // Operands are extended to the product width first, so the truncated
  // PROD_W-bit product is exact in both signed and unsigned forms.
  if (SIGNED != 0) begin : g_signed
    assign o_p = PROD_W'($signed(i_a)) * PROD_W'($signed(i_b));
  end else begin : g_unsigned
    assign o_p = PROD_W'(i_a) * PROD_W'(i_b);
  end

endmodule

// File: rtl/pe_mac_dbuf.sv
// rtl/pe_mac_dbuf.sv - systolic PE with double-buffered weights and WS/OS modes
//
// Purpose : one processing element of an R x C systolic array. In weight-
//           stationary mode it adds a_in * active weight to the partial sum
//           flowing down; in output-stationary mode it accumulates
//           a_in * b_in locally and drains on request. Weights are double
//           buffered (shadow load, swap to active). Every path has exactly
//           one cycle of latency; en=0 freezes all state.
// Config  : PE_SAT_EN - saturating adds/accumulates plus sticky ovf output;
//           undefined gives wrap-around arithmetic and no ovf port.
// Ports   : clk, rst_n (sync, active low), en (advance), mode (0 WS / 1 OS)
//           a_in/a_vld_in -> a_out/a_vld_out   activation pass-through
//           b_in -> b_out                      weight chain / OS operand
//           wload, wswap                       shadow load, shadow->active
//           sum_in -> sum_out                  WS partial sum / OS drain
//           acc_clr, drain                     OS accumulator control
//           ovf (PE_SAT_EN only)               sticky clamp flag

module pe_mac_dbuf
  import pe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int W_W    = 8,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vld_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vld_out,
  input  logic [W_W-1:0]    b_in,
  output logic [W_W-1:0]    b_out,
  input  logic              wload,
  input  logic              wswap,
  input  logic [ACC_W-1:0]  sum_in,
  output logic [ACC_W-1:0]  sum_out,
  input  logic              acc_clr,
  input  logic              drain
`ifdef PE_SAT_EN
  ,
  output logic              ovf
`endif
);

  localparam int PROD_W = DATA_W + W_W;

  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("pe_mac_dbuf: ACC_W must be >= DATA_W + W_W");
  end
`ifdef PE_SAT_EN
  if (ACC_W > SAT_W - 2) begin : g_bad_sat_w
    $error("pe_mac_dbuf: ACC_W too wide for the saturating adder");
  end
`endif

  logic [DATA_W-1:0] r_a_out;
  logic              r_a_vld;
  logic [W_W-1:0]    r_b_out;
  logic [ACC_W-1:0]  r_sum_out;
  logic [W_W-1:0]    r_w_shadow;
  logic [W_W-1:0]    r_w_active;
  logic [ACC_W-1:0]  r_acc;

  logic [W_W-1:0]    w_w_sel;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_prod_ext;
  logic [ACC_W-1:0]  w_acc_base;
  logic [ACC_W-1:0]  w_acc_next;
  logic [ACC_W-1:0]  w_ws_sum;

  // OS streams its second operand straight from b_in; WS uses the
  // stationary weight.
  assign w_w_sel = (mode == PE_MODE_OS) ? b_in : r_w_active;

  pe_mul #(
    .DATA_W (DATA_W),
    .W_W    (W_W),
    .SIGNED (SIGNED)
  ) u_mul (
    .i_a (a_in),
    .i_b (w_w_sel),
    .o_p (w_prod)
  );

  if (SIGNED != 0) begin : g_ext_s
    assign w_prod_ext = ACC_W'($signed(w_prod));
  end else begin : g_ext_u
    assign w_prod_ext = ACC_W'(w_prod);
  end

  assign w_acc_base = acc_clr ? '0 : r_acc;

`ifdef PE_SAT_EN
  logic [SAT_W-1:0] w_sum_in_x;
  logic [SAT_W-1:0] w_acc_base_x;
  logic [SAT_W-1:0] w_prod_x;
  sat_res_t         w_ws_res;
  sat_res_t         w_os_res;
  logic             w_ws_clamp;
  logic             w_os_clamp;
  logic             r_ovf;

  if (SIGNED != 0) begin : g_sat_ext_s
    assign w_sum_in_x   = SAT_W'($signed(sum_in));
    assign w_acc_base_x = SAT_W'($signed(w_acc_base));
    assign w_prod_x     = SAT_W'($signed(w_prod_ext));
  end else begin : g_sat_ext_u
    assign w_sum_in_x   = SAT_W'(sum_in);
    assign w_acc_base_x = SAT_W'(w_acc_base);
    assign w_prod_x     = SAT_W'(w_prod_ext);
  end

  assign w_ws_res   = sat_add(w_sum_in_x, w_prod_x, ACC_W, SIGNED != 0);
  assign w_os_res   = sat_add(w_acc_base_x, w_prod_x, ACC_W, SIGNED != 0);
  // Bubbles never clamp: nothing is added on an invalid cycle.
  assign w_ws_clamp = a_vld_in & w_ws_res.clamp;
  assign w_os_clamp = a_vld_in & w_os_res.clamp;
  assign ovf        = r_ovf;
`endif

  always_comb begin
    w_ws_sum   = sum_in;
    w_acc_next = w_acc_base;
    if (a_vld_in) begin
`ifdef PE_SAT_EN
      w_ws_sum   = w_ws_res.sum[ACC_W-1:0];
      w_acc_next = w_os_res.sum[ACC_W-1:0];
`else
      w_ws_sum   = sum_in + w_prod_ext;
      w_acc_next = w_acc_base + w_prod_ext;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_out    <= '0;
      r_a_vld    <= 1'b0;
      r_b_out    <= '0;
      r_sum_out  <= '0;
      r_w_shadow <= '0;
      r_w_active <= '0;
      r_acc      <= '0;
`ifdef PE_SAT_EN
      r_ovf      <= 1'b0;
`endif
    end else if (en) begin
      r_a_out <= a_in;
      r_a_vld <= a_vld_in;
      r_b_out <= b_in;
      // Weight registers update in both modes so the next WS pass can be
      // preloaded during OS work. With wload and wswap together, active
      // takes the pre-load shadow value (non-blocking read).
      if (wload) r_w_shadow <= b_in;
      if (wswap) r_w_active <= r_w_shadow;
      if (mode == PE_MODE_WS) begin
        r_sum_out <= w_ws_sum;
      end else begin
        r_acc <= w_acc_next;
        // Drain presents the pre-update accumulator.
        if (drain) r_sum_out <= r_acc;
      end
`ifdef PE_SAT_EN
      r_ovf <= (r_ovf & ~acc_clr) |
               ((mode == PE_MODE_WS) ? w_ws_clamp : w_os_clamp);
`endif
    end
  end

  assign a_out     = r_a_out;
  assign a_vld_out = r_a_vld;
  assign b_out     = r_b_out;
  assign sum_out   = r_sum_out;

endmodule

// File: tb/tb_pe_mac_dbuf.sv
// tb/tb_pe_mac_dbuf.sv - self-checking bench for pe_mac_dbuf

module tb_pe_mac_dbuf;

  logic        clk = 1'b0;
  logic        rst_n, en, mode, a_vld_in, wload, wswap, acc_clr, drain;
  logic [7:0]  a_in, b_in;
  logic [23:0] sum_in;

  logic [7:0]  a_out_s, b_out_s, a_out_u, b_out_u, a_out_16, b_out_16;
  logic        avo_s, avo_u, avo_16;
  logic [23:0] sum_s, sum_u;
  logic [15:0] sum_16;
`ifdef PE_SAT_EN
  logic        ovf_s, ovf_u, ovf_16;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_mac_dbuf #(.DATA_W(8), .W_W(8), .ACC_W(24), .SIGNED(1)) u_s (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .a_in(a_in), .a_vld_in(a_vld_in), .a_out(a_out_s), .a_vld_out(avo_s),
    .b_in(b_in), .b_out(b_out_s), .wload(wload), .wswap(wswap),
    .sum_in(sum_in), .sum_out(sum_s), .acc_clr(acc_clr), .drain(drain)
`ifdef PE_SAT_EN
    , .ovf(ovf_s)
`endif
  );

  pe_mac_dbuf #(.DATA_W(8), .W_W(8), .ACC_W(24), .SIGNED(0)) u_u (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .a_in(a_in), .a_vld_in(a_vld_in), .a_out(a_out_u), .a_vld_out(avo_u),
    .b_in(b_in), .b_out(b_out_u), .wload(wload), .wswap(wswap),
    .sum_in(sum_in), .sum_out(sum_u), .acc_clr(acc_clr), .drain(drain)
`ifdef PE_SAT_EN
    , .ovf(ovf_u)
`endif
  );

  pe_mac_dbuf #(.DATA_W(8), .W_W(8), .ACC_W(16), .SIGNED(1)) u_16 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .a_in(a_in), .a_vld_in(a_vld_in), .a_out(a_out_16), .a_vld_out(avo_16),
    .b_in(b_in), .b_out(b_out_16), .wload(wload), .wswap(wswap),
    .sum_in(sum_in[15:0]), .sum_out(sum_16), .acc_clr(acc_clr), .drain(drain)
`ifdef PE_SAT_EN
    , .ovf(ovf_16)
`endif
  );

  typedef struct {
    string       name;
    logic        mode;
    logic [7:0]  a;
    logic        av;
    logic [7:0]  b;
    logic        wl;
    logic        ws;
    logic [23:0] sin;
    logic        clr;
    logic        drn;
    logic [23:0] exp_sum;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic md, input int a, input logic av,
                     input int b, input logic wl, input logic ws, input int sin,
                     input logic clr, input logic drn, input int exp_sum);
    vec_t v;
    v.name = nm; v.mode = md; v.a = 8'(a); v.av = av; v.b = 8'(b);
    v.wl = wl; v.ws = ws; v.sin = 24'(sin); v.clr = clr; v.drn = drn;
    v.exp_sum = 24'(exp_sum);
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, sample 1 time unit later.
  task automatic step(input logic e, input logic md, input int a, input logic av,
                      input int b, input logic wl, input logic ws, input int sin,
                      input logic clr, input logic drn);
    en = e; mode = md; a_in = 8'(a); a_vld_in = av; b_in = 8'(b);
    wload = wl; wswap = ws; sum_in = 24'(sin); acc_clr = clr; drain = drn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with every input nonzero.
    rst_n = 1'b0;
    en = 1'b1; mode = 1'b1; a_in = 8'h11; a_vld_in = 1'b1; b_in = 8'h22;
    wload = 1'b1; wswap = 1'b1; sum_in = 24'h33; acc_clr = 1'b1; drain = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_a_out", 32'(a_out_s), 32'h0);
    chk("rst_a_vld", 32'(avo_s), 32'h0);
    chk("rst_b_out", 32'(b_out_s), 32'h0);
    chk("rst_sum",   32'(sum_s), 32'h0);
`ifdef PE_SAT_EN
    chk("rst_ovf",   32'(ovf_16), 32'h0);
`endif
    rst_n = 1'b1;
    // Active weight must be 0 after reset: sum passes through unchanged.
    step(1, 0, 5, 1, 0, 0, 0, 100, 0, 0);
    chk("post_rst_sum", 32'(sum_s), 32'd100);
    chk("post_rst_a",   32'(a_out_s), 32'd5);

    //   name          md  a     av b     wl ws sin clr drn exp
    add("ws_load3",    0,  0,    0, 3,    1, 0, 0,  0,  0,  0);
    add("ws_swap3",    0,  0,    0, 0,    0, 1, 0,  0,  0,  0);
    add("ws_mac22",    0,  4,    1, 0,    0, 0, 10, 0,  0,  22);
    add("ws_ld_sw",    0,  0,    0, 'hFE, 1, 1, 0,  0,  0,  0);
    add("ws_old_w",    0,  4,    1, 0,    0, 0, 10, 0,  0,  22);
    add("ws_swap_m2",  0,  0,    0, 0,    0, 1, 0,  0,  0,  0);
    add("ws_neg_w",    0,  4,    1, 0,    0, 0, 10, 0,  0,  2);
    add("ws_bubble",   0,  9,    0, 0,    0, 0, 7,  0,  0,  7);
    add("ws_neg_neg",  0,  'hFD, 1, 0,    0, 0, 0,  0,  0,  6);
    add("os_clr",      1,  2,    1, 3,    0, 0, 99, 1,  0,  6);
    add("os_acc2",     1,  'hFF, 1, 4,    0, 0, 99, 0,  0,  6);
    add("os_acc3",     1,  5,    1, 5,    0, 0, 99, 0,  0,  6);
    add("os_drain27",  1,  0,    0, 0,    0, 0, 0,  0,  1,  27);
    add("os_drn_clr",  1,  3,    1, 7,    0, 0, 0,  1,  1,  27);
    add("os_drain21",  1,  0,    0, 0,    0, 0, 0,  0,  1,  21);
    add("os_clr_bub",  1,  0,    0, 0,    0, 0, 0,  1,  0,  21);
    add("os_drain0",   1,  0,    0, 0,    0, 0, 0,  0,  1,  0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(1, vecs[i].mode, int'(vecs[i].a), vecs[i].av, int'(vecs[i].b),
           vecs[i].wl, vecs[i].ws, int'(vecs[i].sin), vecs[i].clr, vecs[i].drn);
      chk({vecs[i].name, "_sum"},  32'(sum_s), 32'(vecs[i].exp_sum));
      chk({vecs[i].name, "_a"},    32'(a_out_s), 32'(vecs[i].a));
      chk({vecs[i].name, "_avld"}, 32'(avo_s), 32'(vecs[i].av));
      chk({vecs[i].name, "_b"},    32'(b_out_s), 32'(vecs[i].b));
    end

    // Stall: active weight is -2, shadow is -2.
    step(1, 0, 1, 1, 'h12, 0, 0, 50, 0, 0);
    chk("pre_stall_sum", 32'(sum_s), 32'd48);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 7, 0, 'h55, 1, 1, 999, 1, 1);
      chk("stall_sum",  32'(sum_s), 32'd48);
      chk("stall_a",    32'(a_out_s), 32'd1);
      chk("stall_avld", 32'(avo_s), 32'd1);
      chk("stall_b",    32'(b_out_s), 32'h12);
    end
    // If the stalled wload had landed, this swap would expose 0x55.
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("stall_w_kept", 32'(sum_s), 32'hFFFFFE);

    // Unsigned full-scale product.
    step(1, 0, 0, 0, 'hFF, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 'hFF, 1, 0, 0, 0, 0, 0, 0);
    chk("uns_ff_ff", 32'(sum_u), 32'd65025);
    chk("sgn_ff_ff", 32'(sum_s), 32'd1);

    // 16-bit accumulator overflow: 32760 + 100.
    step(1, 0, 0, 0, 10, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 10, 1, 0, 0, 0, 32760, 0, 0);
    chk("acc24_no_ovf", 32'(sum_s), 32'd32860);
    chk("uns_no_ovf",   32'(sum_u), 32'd32860);
`ifdef PE_SAT_EN
    chk("acc16_sat",    32'(sum_16), 32'd32767);
    chk("ovf_set",      32'(ovf_16), 32'd1);
    chk("ovf_s_clear",  32'(ovf_s), 32'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ovf_sticky",   32'(ovf_16), 32'd1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("ovf_clr",      32'(ovf_16), 32'd0);
`else
    chk("acc16_wrap",   32'(sum_16), 32'(16'h805C));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
